// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C command sequencer and its FIFO.
// A command entry is {rw, data}; rw selects read (1) or write (0).
package i2c_pkg;

   localparam int   CMD_W    = 9;
   localparam logic RW_WRITE = 1'b0;
   localparam logic RW_READ  = 1'b1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      WAIT  = 3'd2,
      RESP  = 3'd3,
      GAP   = 3'd4
   } seq_state_t;

   function automatic logic [CMD_W-1:0] pack_cmd(input logic rw, input logic [7:0] data);
      return {rw, data};
   endfunction

endpackage

// File: rtl/i2c_cmd_fifo.sv
// Synchronous FIFO with show-ahead head output and an occupancy count.
// Writes while full and reads while empty are ignored.
module i2c_cmd_fifo
   import i2c_pkg::*;
#(
   parameter  int DEPTH = 4,
   parameter  int WIDTH = CMD_W,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      level
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             wr_en;
   logic             rd_en;

   assign full  = (level == (AW+1)'(DEPTH));
   assign empty = (level == '0);
   assign wr_en = push && !full;
   assign rd_en = pop && !empty;
   assign dout  = mem[rd_ptr];

   // DEPTH is a power of two, so the pointers wrap by plain overflow.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, rd_en})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// Buffers host read/write commands and issues them one at a time to the
// I2C master, returning read bytes and guarding against a hung bus.
module i2c_cmd_sequencer
   import i2c_pkg::*;
#(
   parameter int DEPTH          = 4,
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int GAP_CYCLES     = 10
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic                     cmd_rw,
   input  logic [7:0]               cmd_data,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [7:0]               rsp_data,
   output logic                     m_start,
   output logic                     m_rw,
   output logic [7:0]               m_din,
   input  logic                     m_done,
   input  logic [7:0]               m_rx_data,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     err_timeout,
   input  logic                     err_clr,
   output seq_state_t               state_dbg
);

   // Handshakes: cmd and rsp transfer on a rising clk edge where valid && ready
   // are both high; rsp_valid/rsp_data stay stable until that edge.

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + GAP_CYCLES + 2);
   localparam logic [CNT_W-1:0] TO_LOAD  = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
   localparam seq_state_t       AFTER_CMD = (GAP_CYCLES > 0) ? GAP : IDLE;

   seq_state_t        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              m_done_q;
   logic              done_rise;
   logic              fifo_pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic [CMD_W-1:0]  fifo_head;
   logic              m_rw_d;
   logic [7:0]        m_din_d;
   logic              rsp_valid_d;
   logic [7:0]        rsp_data_d;
   logic              err_set;

   i2c_cmd_fifo #(.DEPTH(DEPTH), .WIDTH(CMD_W)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (cmd_valid && cmd_ready),
      .din   (pack_cmd(cmd_rw, cmd_data)),
      .pop   (fifo_pop),
      .dout  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (level)
   );

   assign cmd_ready = !fifo_full;
   assign done_rise = m_done && !m_done_q;
   assign m_start   = (state_q == ISSUE);
   assign busy      = (state_q != IDLE) || !fifo_empty;
   assign state_dbg = state_q;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      fifo_pop    = 1'b0;
      m_rw_d      = m_rw;
      m_din_d     = m_din;
      rsp_valid_d = rsp_valid;
      rsp_data_d  = rsp_data;
      err_set     = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_pop          = 1'b1;
               {m_rw_d, m_din_d} = fifo_head;
               state_d           = ISSUE;
            end
         end
         ISSUE: begin
            cnt_d   = TO_LOAD;
            state_d = WAIT;
         end
         WAIT: begin
            if (done_rise) begin
               if (m_rw == RW_READ) begin
                  rsp_valid_d = 1'b1;
                  rsp_data_d  = m_rx_data;
                  state_d     = RESP;
               end else begin
                  cnt_d   = GAP_LOAD;
                  state_d = AFTER_CMD;
               end
            end else if (cnt_q <= CNT_W'(1)) begin
               // The counter reaches zero on this cycle: give up on the master.
               err_set = 1'b1;
               cnt_d   = GAP_LOAD;
               state_d = AFTER_CMD;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               cnt_d       = GAP_LOAD;
               state_d     = AFTER_CMD;
            end
         end
         GAP: begin
            if (cnt_q == '0) state_d = IDLE;
            else             cnt_d   = cnt_q - 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         m_done_q    <= 1'b0;
         m_rw        <= 1'b0;
         m_din       <= '0;
         rsp_valid   <= 1'b0;
         rsp_data    <= '0;
         err_timeout <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         m_done_q  <= m_done;
         m_rw      <= m_rw_d;
         m_din     <= m_din_d;
         rsp_valid <= rsp_valid_d;
         rsp_data  <= rsp_data_d;
         // A new timeout outranks a clear on the same cycle.
         if (err_set)      err_timeout <= 1'b1;
         else if (err_clr) err_timeout <= 1'b0;
      end
   end

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Bench for i2c_cmd_sequencer with a behavioural master stub and
// scoreboards for issued commands and returned read bytes.
module tb_i2c_cmd_sequencer;
   import i2c_pkg::*;

   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 16;
   localparam int GAP     = 10;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic       cmd_rw = 1'b0;
   logic [7:0] cmd_data = '0;
   logic       rsp_valid;
   logic       rsp_ready = 1'b1;
   logic [7:0] rsp_data;
   logic       m_start;
   logic       m_rw;
   logic [7:0] m_din;
   logic       m_done = 1'b0;
   logic [7:0] m_rx_data = '0;
   logic       busy;
   logic [$clog2(DEPTH):0] level;
   logic       err_timeout;
   logic       err_clr = 1'b0;
   seq_state_t state_dbg;

   i2c_cmd_sequencer #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TIMEOUT), .GAP_CYCLES(GAP)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_rw(cmd_rw), .cmd_data(cmd_data), .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready), .rsp_data(rsp_data), .m_start(m_start),
      .m_rw(m_rw), .m_din(m_din), .m_done(m_done), .m_rx_data(m_rx_data),
      .busy(busy), .level(level), .err_timeout(err_timeout),
      .err_clr(err_clr), .state_dbg(state_dbg)
   );

   // clock / cycle counter
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // scoreboard state
   logic [CMD_W-1:0] exp_cmd_q[$];
   logic [7:0]       exp_rsp_q[$];
   int total = 0;
   int bad   = 0;

   int         start_count = 0, start_cyc = 0, push_cyc = 0;
   int         done_cyc = 0, err_count = 0, err_cyc = 0, rsp_count = 0;
   logic       done_valid = 1'b0;
   logic       stall_done = 1'b0;
   logic [7:0] rx_byte = 8'h00;
   logic [7:0] slave_data = 8'h00;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
      end
   endtask

   // master stub + monitor, sampled 1 time unit after the falling edge
   initial begin : bus
      logic             prev_start;
      logic             prev_err;
      int               pend;
      logic [CMD_W-1:0] cur_cmd;
      prev_start = 1'b0; prev_err = 1'b0; pend = 0; cur_cmd = '0;
      forever begin
         @(negedge clk); #1;
         if (!rst) begin
            m_done = 1'b0; pend = 0; prev_start = 1'b0;
            prev_err = 1'b0; done_valid = 1'b0;
         end else begin
            if (prev_start) check_eq("start_pulse", m_start, 1'b0);
            if (m_start) begin
               start_count++;
               start_cyc = cyc;
               if (done_valid) check_eq("gap_min", (cyc - done_cyc) >= GAP + 2, 1'b1);
               done_valid = 1'b0;
               if (exp_cmd_q.size() == 0) check_eq("cmd_q_nonempty", exp_cmd_q.size() != 0, 1'b1);
               else begin
                  cur_cmd = exp_cmd_q.pop_front();
                  check_eq("m_cmd", {m_rw, m_din}, cur_cmd);
               end
               m_done = 1'b0;
               pend   = $urandom_range(2, 8);
            end else if (pend > 0) begin
               pend--;
               if (pend == 0 && !stall_done) begin
                  check_eq("m_hold", {m_rw, m_din}, cur_cmd);
                  if (cur_cmd[8] == RW_READ) begin
                     m_rx_data = rx_byte;
                     exp_rsp_q.push_back(rx_byte);
                  end else begin
                     slave_data = cur_cmd[7:0];
                  end
                  m_done     = 1'b1;
                  done_cyc   = cyc;
                  done_valid = 1'b1;
               end
            end
            if (rsp_valid && rsp_ready) begin
               rsp_count++;
               if (exp_rsp_q.size() == 0) check_eq("rsp_q_nonempty", exp_rsp_q.size() != 0, 1'b1);
               else check_eq("rsp_data", rsp_data, exp_rsp_q.pop_front());
            end
            if (err_timeout && !prev_err) begin
               err_count++;
               err_cyc = cyc;
            end
            prev_err   = err_timeout;
            prev_start = m_start;
         end
      end
   end

   // driver tasks (called at a falling edge)
   task automatic push_cmd(input logic rw, input logic [7:0] data, output int held);
      held = 0;
      cmd_valid = 1'b1; cmd_rw = rw; cmd_data = data;
      while (!cmd_ready && held < 200) begin @(negedge clk); held++; end
      if (!cmd_ready) check_eq("push_ready", cmd_ready, 1'b1);
      else begin
         push_cyc = cyc;
         exp_cmd_q.push_back(pack_cmd(rw, data));
      end
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 400) begin @(negedge clk); n++; end
      if (busy) check_eq("idle_wait", busy, 1'b0);
   endtask

   task automatic wait_start(input int target);
      int n = 0;
      while (start_count < target && n < 300) begin @(negedge clk); n++; end
      if (start_count < target) check_eq("start_wait", start_count, target);
   endtask

   task automatic wait_err(input int target);
      int n = 0;
      while (err_count < target && n < 300) begin @(negedge clk); n++; end
      if (err_count < target) check_eq("err_wait", err_count, target);
   endtask

   initial begin : main
      int held, s0, r0, n;
      logic stable;

      // reset values
      repeat (3) @(negedge clk);
      check_eq("rst_cmd_ready", cmd_ready, 1'b1);
      check_eq("rst_level", level, 0);
      check_eq("rst_busy", busy, 1'b0);
      check_eq("rst_rsp_valid", rsp_valid, 1'b0);
      check_eq("rst_rsp_data", rsp_data, 8'h00);
      check_eq("rst_m_start", m_start, 1'b0);
      check_eq("rst_m_cmd", {m_rw, m_din}, 9'h000);
      check_eq("rst_err", err_timeout, 1'b0);
      check_eq("rst_state", state_dbg, IDLE);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // 1: single write
      r0 = rsp_count;
      push_cmd(RW_WRITE, 8'hBE, held);
      wait_start(1);
      check_eq("start_latency", start_cyc - push_cyc, 2);
      n = 0;
      while (!(done_valid == 1'b0 && busy == 1'b0) && n < 100) begin
         @(negedge clk); n++;
         if (!busy) break;
      end
      check_eq("busy_drop", cyc - done_cyc, GAP + 1);
      check_eq("slave_data", slave_data, 8'hBE);
      check_eq("write_no_rsp", rsp_count, r0);

      // 2: read with host back-pressure
      rx_byte = 8'hA5;
      rsp_ready = 1'b0;
      push_cmd(RW_READ, 8'h3C, held);
      n = 0;
      while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
      check_eq("read_valid", rsp_valid, 1'b1);
      check_eq("read_data", rsp_data, 8'hA5);
      s0 = start_count;
      stable = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (!rsp_valid || rsp_data !== 8'hA5) stable = 1'b0;
      end
      check_eq("rsp_stable", stable, 1'b1);
      check_eq("no_issue_in_resp", start_count, s0);
      rsp_ready = 1'b1;
      @(negedge clk);
      check_eq("rsp_cleared", rsp_valid, 1'b0);
      wait_idle();

      // 3: fill FIFO behind a running command, check order and back-pressure
      rx_byte = 8'($urandom_range(0, 255));
      r0 = rsp_count;
      push_cmd(RW_WRITE, 8'h10, held);
      wait_start(start_count + 1);
      push_cmd(RW_WRITE, 8'h11, held);
      push_cmd(RW_WRITE, 8'h22, held);
      push_cmd(RW_READ,  8'h5C, held);
      push_cmd(RW_WRITE, 8'h33, held);
      check_eq("fill_level", level, 4);
      check_eq("fill_ready", cmd_ready, 1'b0);
      push_cmd(RW_WRITE, 8'h44, held);
      check_eq("fifth_held", held > 0, 1'b1);
      wait_idle();
      repeat (2) @(negedge clk);
      check_eq("fill_rsp_count", rsp_count - r0, 1);

      // 4: timeout, then the queued command issues after the gap
      stall_done = 1'b1;
      s0 = start_count;
      push_cmd(RW_WRITE, 8'h5A, held);
      push_cmd(RW_WRITE, 8'h6B, held);
      wait_err(1);
      check_eq("timeout_delay", err_cyc - start_cyc, TIMEOUT);
      stall_done = 1'b0;
      wait_start(s0 + 2);
      check_eq("after_timeout_issue", start_cyc - err_cyc, GAP + 1);
      wait_idle();
      check_eq("err_sticky", err_timeout, 1'b1);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      check_eq("err_cleared", err_timeout, 1'b0);
      // set on the same cycle as a held clear must still show the flag
      err_clr = 1'b1;
      stall_done = 1'b1;
      push_cmd(RW_WRITE, 8'h77, held);
      wait_err(2);
      check_eq("err_set_wins", err_cyc - start_cyc, TIMEOUT);
      check_eq("err_clr_after", err_timeout, 1'b0);
      err_clr = 1'b0;
      wait_idle();

      // 5: asynchronous reset while waiting with two entries queued
      s0 = start_count;
      push_cmd(RW_READ, 8'hC3, held);
      wait_start(s0 + 1);
      push_cmd(RW_WRITE, 8'h01, held);
      push_cmd(RW_WRITE, 8'h02, held);
      check_eq("pre_rst_level", level, 2);
      #2 rst = 1'b0;
      #1;
      check_eq("arst_level", level, 0);
      check_eq("arst_cmd_ready", cmd_ready, 1'b1);
      check_eq("arst_busy", busy, 1'b0);
      check_eq("arst_m_cmd", {m_rw, m_din}, 9'h000);
      check_eq("arst_state", state_dbg, IDLE);
      exp_cmd_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      stall_done = 1'b0;
      s0 = start_count;
      repeat (30) @(negedge clk);
      check_eq("no_start_after_rst", start_count, s0);
      push_cmd(RW_WRITE, 8'h9E, held);
      wait_start(s0 + 1);
      wait_idle();

      // 6: push on the same cycle as the IDLE pop
      push_cmd(RW_WRITE, 8'hA1, held);
      check_eq("pp_level_a", level, 1);
      push_cmd(RW_WRITE, 8'hB2, held);
      check_eq("pp_level_b", level, 1);
      wait_idle();

      repeat (3) @(negedge clk);
      check_eq("cmd_q_drained", exp_cmd_q.size(), 0);
      check_eq("rsp_q_drained", exp_rsp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/i2c_cmd_sequencer.md
Name: i2c_cmd_sequencer

Overview:
Command front-end that sits directly upstream of i2c_master_rw. It buffers byte-level read/write commands from a host in a small FIFO. It issues them one at a time to the master via start/rw/din, waits for the master's done, and returns read bytes on a valid/ready response port. It also enforces an inter-transaction gap and a done timeout, so a hung bus cannot stall the host forever.

Parameters:
DEPTH, 4, command FIFO entries; power of two, minimum 2
TIMEOUT_CYCLES, 4096, clk cycles to wait for done after a start before aborting
GAP_CYCLES, 10, idle clk cycles enforced after each completed or aborted command

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset (0 = reset)
cmd_valid  in  1  host command valid
cmd_ready  out  1  FIFO can accept; equals not-full
cmd_rw  in  1  0 = write, 1 = read
cmd_data  in  8  write byte (ignored for reads, still stored)
rsp_valid  out  1  read byte available
rsp_ready  in  1  host accepts read byte
rsp_data  out  8  read byte
m_start  out  1  one-cycle start pulse to master
m_rw  out  1  rw to master, held stable from start until done
m_din  out  8  data to master, held stable from start until done
m_done  in  1  master done (level; rising edge is significant)
m_rx_data  in  8  master read data, valid when m_done rises
busy  out  1  state != IDLE or FIFO non-empty
level  out  $clog2(DEPTH)+1  FIFO occupancy
err_timeout  out  1  sticky timeout flag
err_clr  in  1  clears err_timeout

Behaviour:
- Reset (rst=0, async): FIFO flushed, level=0, state=IDLE, and all of cmd_ready=1, rsp_valid=0, rsp_data=0, m_start=0, m_rw=0, m_din=0, busy=0, err_timeout=0. A reset mid-transaction abandons the command with no response; the master shares rst.
- FIFO: push when cmd_valid && cmd_ready. Pop only in IDLE. Push on the same cycle as a pop is allowed: level is unchanged and the entry is stored correctly. When full, cmd_ready=0 and cmd_valid is ignored. Pointers wrap modulo DEPTH.
- m_done edge detect: register m_done; done_rise = m_done && !m_done_q.
- States:
  - IDLE: if FIFO non-empty, pop the head, latch it into m_rw/m_din, and go to ISSUE. First-word latency from push to m_start is 2 cycles.
  - ISSUE: m_start=1 for exactly this cycle; load the timeout counter with TIMEOUT_CYCLES-1; go to WAIT.
  - WAIT: done_rise takes priority over timeout on the same cycle.
    - On done_rise with m_rw=1: capture m_rx_data into rsp_data, set rsp_valid, and go to RESP.
    - On done_rise with m_rw=0: go to GAP.
    - When the counter reaches 0 without done_rise: set err_timeout and go to GAP. No response is produced.
  - RESP: hold rsp_valid and rsp_data stable until rsp_ready. On the handshake cycle clear rsp_valid and go to GAP. No new command issues while a response is pending.
  - GAP: count GAP_CYCLES cycles, then go to IDLE. If GAP_CYCLES=0, go straight to IDLE.
- m_rw and m_din stay held until the next pop.
- err_timeout: a set on the same cycle as err_clr wins (the flag stays 1).
- Commands complete strictly in FIFO order; responses come only for reads.

Decomposition:
- Shared package i2c_pkg: state encoding constants (IDLE, ISSUE, WAIT, RESP, GAP), CMD_W=9 for the {rw, data} entry width, RW_WRITE=0 and RW_READ=1.
- One natural sub-module: i2c_cmd_fifo, a sync FIFO parameterised by DEPTH and width, with push/pop/full/empty/level outputs. The sequencer FSM lives in the top.

Test Plan:
1. Single write: push {rw=0, 0xBE} with i2c_master_rw and slave@0x50 attached -> exactly one m_start pulse 2 cycles later with m_rw=0 and m_din=0xBE; done rises; no rsp_valid; slave received_data=0xBE; busy drops GAP_CYCLES+1 cycles after done.
2. Read: push {rw=1, x} with the slave's send_data=0xA5 -> rsp_valid with rsp_data=0xA5; with rsp_ready held 0 for 20 cycles, rsp_valid and rsp_data stay stable and no second m_start occurs; rsp_ready=1 then completes the handshake.
3. Fill and order: push write 0x11, write 0x22, read, write 0x33 back-to-back -> level reaches 4 and cmd_ready=0; a 5th push is held off until the first pop. Master sees m_din 0x11, 0x22, x, 0x33 in order with gaps of at least GAP_CYCLES; one response is returned.
4. Timeout: stub m_done tied to 0 with TIMEOUT_CYCLES=16 -> err_timeout rises 16 cycles after m_start and the next queued command then issues after the gap. err_clr=1 clears the flag; err_clr asserted on the same cycle as a new timeout leaves err_timeout=1.
5. Reset mid-WAIT: assert rst=0 while 2 entries are queued -> outputs take their reset values immediately (asynchronously), level=0, and no m_start after release until a new push.
6. Simultaneous push/pop: push on the same cycle as the IDLE pop with level=1 -> level stays 1 and the pushed entry is issued next.
